// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer for the century clock: mode button walks the field selection,
// up/down issue one-cycle strobes to the selected counter, with hold-to-repeat and idle timeout.
module clock_set_ctrl #(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    parameter int TIMEOUT       = 10000,
    parameter int BLINK_HALF    = 250,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       run_en,
    output logic [2:0] sel,
    output logic [5:0] inc,
    output logic [5:0] dec,
    output logic       blink
);

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_SEC  = 3'd1,
        S_MIN  = 3'd2,
        S_HOUR = 3'd3,
        S_DAY  = 3'd4,
        S_MON  = 3'd5,
        S_YEAR = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] C_DELAY_END  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] C_PERIOD_END = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] C_IDLE_END   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_BLINK_END  = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

    // Button vectors are ordered {mode, down, up}.
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_prev;
    state_t           r_state;
    logic             r_rep_act;
    logic             r_rep_dir;
    logic             r_rep_phase;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_run_en;
    logic [2:0]       r_sel;
    logic [5:0]       r_inc;
    logic [5:0]       r_dec;
    logic             r_blink;

    logic [2:0] w_rise;
    logic       w_up;
    logic       w_dn;
    logic       w_both;
    logic       w_set;
    logic       w_held;
    logic       w_rep_hit;
    logic       w_block;
    logic       w_up_stb;
    logic       w_dn_stb;
    logic       w_stb;
    logic       w_timeout;
    logic [5:0] w_field;
    state_t     w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= {btn_mode, btn_down, btn_up};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise  = r_sync2 & ~r_prev;
    assign w_up    = r_sync2[0];
    assign w_dn    = r_sync2[1];
    assign w_both  = w_up & w_dn;
    assign w_set   = (r_state != S_RUN);
    // Repeat continues only while the button that earned the press strobe is held alone.
    assign w_held    = r_rep_dir ? (w_dn & ~w_up) : (w_up & ~w_dn);
    assign w_rep_hit = r_rep_act & w_held &
                       (r_rep_cnt == (r_rep_phase ? C_PERIOD_END : C_DELAY_END));
    assign w_block   = ~w_set | w_rise[2] | w_both;
    assign w_up_stb  = ~w_block & (w_rise[0] | (w_rep_hit & ~r_rep_dir));
    assign w_dn_stb  = ~w_block & (w_rise[1] | (w_rep_hit & r_rep_dir));
    assign w_stb     = w_up_stb | w_dn_stb;
    assign w_timeout = w_set & ~(|w_rise) & ~w_stb & (r_idle_cnt == C_IDLE_END);
    assign w_field   = 6'b000001 << (r_state - 3'd1);

    always_comb begin
        w_next = r_state;
        if (w_rise[2]) begin
            if (r_state == S_YEAR) w_next = S_RUN;
            else                   w_next = state_t'(r_state + 3'd1);
        end else if (w_timeout) begin
            w_next = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_sel       <= 3'd0;
            r_run_en    <= 1'b1;
            r_inc       <= '0;
            r_dec       <= '0;
            r_rep_act   <= 1'b0;
            r_rep_dir   <= 1'b0;
            r_rep_phase <= 1'b0;
            r_rep_cnt   <= '0;
            r_idle_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_sel    <= w_next;
            r_run_en <= (w_next == S_RUN);
            r_inc    <= w_up_stb ? w_field : 6'b0;
            r_dec    <= w_dn_stb ? w_field : 6'b0;

            if (w_block || w_timeout) begin
                r_rep_act   <= 1'b0;
                r_rep_phase <= 1'b0;
                r_rep_cnt   <= '0;
            end else if (w_rise[0] || w_rise[1]) begin
                r_rep_act   <= 1'b1;
                r_rep_dir   <= w_rise[1];
                r_rep_phase <= 1'b0;
                r_rep_cnt   <= '0;
            end else if (w_rep_hit) begin
                r_rep_phase <= 1'b1;
                r_rep_cnt   <= '0;
            end else if (r_rep_act && w_held) begin
                if (r_rep_cnt != C_CNT_MAX) r_rep_cnt <= r_rep_cnt + C_ONE;
            end else begin
                r_rep_act   <= 1'b0;
                r_rep_phase <= 1'b0;
                r_rep_cnt   <= '0;
            end

            if (w_next == S_RUN || (|w_rise) || w_stb) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != C_CNT_MAX) begin
                r_idle_cnt <= r_idle_cnt + C_ONE;
            end

            // Blink phase restarts on field entry and on each strobe so the new value shows at once.
            if (w_next == S_RUN || w_rise[2] || w_stb) begin
                r_blink     <= 1'b0;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == C_BLINK_END) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + C_ONE;
            end
        end
    end

    assign run_en = r_run_en;
    assign sel    = r_sel;
    assign inc    = r_inc;
    assign dec    = r_dec;
    assign blink  = r_blink;

endmodule
